// File: rtl/irrigation_condition_monitor.sv
// Per-zone irrigation valve condition monitor with fault detection and a ready/valid scan port.
// Define IRRIGATION_FAULT_LATCH_EN to make fault flags sticky until clear_i or reset.
module irrigation_condition_monitor #(
  parameter int ZONES        = 4,
  parameter int FAULT_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [ZONES-1:0]     sprinkler_status_i,
  input  logic [ZONES-1:0]     drip_status_i,
  input  logic [ZONES-1:0]     irrigation_status_i,
  input  logic [ZONES-1:0]     clear_i,
  output logic [2*ZONES-1:0]   cond_o,
  output logic                 fault_irq_o,
  output logic                 scan_valid_o,
  input  logic                 scan_ready_i,
  output logic [2:0]           scan_zone_o,
  output logic [1:0]           scan_code_o
);

  localparam logic [7:0] FC      = 8'(FAULT_CYCLES);
  localparam logic [2:0] LAST_Z  = 3'(ZONES - 1);

  logic [ZONES-1:0] s_meta_q, s_q, d_meta_q, d_q, r_meta_q, r_q;
  logic [ZONES-1:0] imm_fault, tmo_cond, set_fault;
  logic [ZONES-1:0] fault_q, fault_d;
  logic [7:0]       cnt_q [ZONES];
  logic [7:0]       cnt_d [ZONES];
  logic [7:0]       cnt_inc [ZONES];
  logic [1:0]       cond_q [ZONES];
  logic [1:0]       cond_d [ZONES];
  logic             irq_q;
  logic             valid_pre_q, valid_q;
  logic [2:0]       scan_zone_q, ptr_next;
  logic [1:0]       scan_code_q, sel_code;
  logic             scan_load;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_meta_q <= '0;
      s_q      <= '0;
      d_meta_q <= '0;
      d_q      <= '0;
      r_meta_q <= '0;
      r_q      <= '0;
    end else begin
      s_meta_q <= sprinkler_status_i;
      s_q      <= s_meta_q;
      d_meta_q <= drip_status_i;
      d_q      <= d_meta_q;
      r_meta_q <= irrigation_status_i;
      r_q      <= r_meta_q;
    end
  end

  // Both valves open is an immediate fault; a request with no valve, or a valve with no request, is a timeout condition.
  assign imm_fault = s_q & d_q;
  assign tmo_cond  = (r_q & ~s_q & ~d_q) | (~r_q & (s_q | d_q));

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    for (int z = 0; z < ZONES; z++) begin
      cnt_inc[z]   = (cnt_q[z] == FC) ? cnt_q[z] : cnt_q[z] + 8'd1;
      set_fault[z] = imm_fault[z] | (tmo_cond[z] & (cnt_inc[z] == FC));
      cnt_d[z]     = tmo_cond[z] ? cnt_inc[z] : 8'd0;
      if (clear_i[z] && !set_fault[z]) cnt_d[z] = 8'd0;
`ifdef IRRIGATION_FAULT_LATCH_EN
      fault_d[z] = set_fault[z] | (fault_q[z] & ~clear_i[z]);
`else
      fault_d[z] = set_fault[z] | (fault_q[z] & (imm_fault[z] | tmo_cond[z]) & ~clear_i[z]);
`endif
      if (fault_d[z])                       cond_d[z] = 2'b11;
      else if (r_q[z] && s_q[z] && !d_q[z]) cond_d[z] = 2'b01;
      else if (r_q[z] && !s_q[z] && d_q[z]) cond_d[z] = 2'b10;
      else                                  cond_d[z] = 2'b00;
    end
  end

  // NOTE: the per-zone arrays are tiny, so they are reset like any other register rather than left as uninitialised storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fault_q <= '0;
      irq_q   <= 1'b0;
      for (int z = 0; z < ZONES; z++) begin
        cnt_q[z]  <= 8'd0;
        cond_q[z] <= 2'b00;
      end
    end else begin
      fault_q <= fault_d;
      irq_q   <= |fault_q;
      for (int z = 0; z < ZONES; z++) begin
        cnt_q[z]  <= cnt_d[z];
        cond_q[z] <= cond_d[z];
      end
    end
  end

  // Scan port: refresh when empty or accepted, otherwise hold the offered pair.
  always_comb begin
    scan_load = ~valid_q | scan_ready_i;
    ptr_next  = scan_zone_q;
    if (valid_q && scan_ready_i) ptr_next = (scan_zone_q == LAST_Z) ? 3'd0 : scan_zone_q + 3'd1;
    sel_code = 2'b00;
    for (int z = 0; z < ZONES; z++) begin
      if (ptr_next == 3'(z)) sel_code = cond_q[z];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_pre_q <= 1'b0;
      valid_q     <= 1'b0;
      scan_zone_q <= 3'd0;
      scan_code_q <= 2'b00;
    end else begin
      valid_pre_q <= 1'b1;
      valid_q     <= valid_pre_q;
      if (scan_load) begin
        scan_zone_q <= ptr_next;
        scan_code_q <= sel_code;
      end
    end
  end

  always_comb begin
    cond_o = '0;
    for (int z = 0; z < ZONES; z++) cond_o[2*z +: 2] = cond_q[z];
  end

  assign fault_irq_o  = irq_q;
  assign scan_valid_o = valid_q;
  assign scan_zone_o  = scan_zone_q;
  assign scan_code_o  = scan_code_q;

endmodule

// File: tb/tb_irrigation_condition_monitor.sv
// Directed bench for irrigation_condition_monitor (ZONES=4, FAULT_CYCLES=8).
module tb_irrigation_condition_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] spr, drip, irr, clr;
  logic       ready;
  logic [7:0] cond;
  logic       irq, valid;
  logic [2:0] zone;
  logic [1:0] code;

  int n_cmp = 0;
  int n_err = 0;

  irrigation_condition_monitor #(.ZONES(4), .FAULT_CYCLES(8)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .sprinkler_status_i  (spr),
    .drip_status_i       (drip),
    .irrigation_status_i (irr),
    .clear_i             (clr),
    .cond_o              (cond),
    .fault_irq_o         (irq),
    .scan_valid_o        (valid),
    .scan_ready_i        (ready),
    .scan_zone_o         (zone),
    .scan_code_o         (code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int exp_zone [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; spr = '0; drip = '0; irr = '0; clr = '0; ready = 1'b0;
    #1;
    check("rst_cond", 32'(cond), 32'h00);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_zone", 32'(zone), 32'h0);
    check("rst_code", 32'(code), 32'h0);
    #11 rst_n = 1'b1;
    tick(1);
    check("valid_edge1", 32'(valid), 32'h0);
    tick(1);
    check("valid_edge2", 32'(valid), 32'h1);

    // Scan holds while not ready, then walks the zones.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("scan_hold_zone", 32'(zone), 32'h0);
    end
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("scan_walk_zone", 32'(zone), 32'(exp_zone[i]));
      tick(1);
    end
    ready = 1'b0;

    // Zone 1 sprinkler request: three-cycle latency.
    irr = 4'b0010; spr = 4'b0010;
    tick(2);
    check("z1_lat2", 32'(cond), 32'h00);
    tick(1);
    check("z1_lat3", 32'(cond), 32'h04);
    check("z1_irq", 32'(irq), 32'h0);
    check("z1_scan_held", 32'(code), 32'h0);
    irr = '0; spr = '0;
    tick(3);
    check("z1_drop", 32'(cond), 32'h00);

    // Zone 2 immediate fault.
    spr = 4'b0100; drip = 4'b0100;
    tick(3);
    check("z2_fault_code", 32'(cond), 32'h30);
    check("z2_irq_c3", 32'(irq), 32'h0);
    tick(1);
    check("z2_irq_c4", 32'(irq), 32'h1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("z2_scan_zone", 32'(zone), 32'h2);
    check("z2_scan_code", 32'(code), 32'h3);
    spr = '0; drip = '0;
    tick(2);
    check("z2_drop2", 32'(cond), 32'h30);
    tick(1);
`ifdef IRRIGATION_FAULT_LATCH_EN
    check("z2_sticky", 32'(cond), 32'h30);
    tick(2);
    check("z2_sticky_late", 32'(cond), 32'h30);
    clr = 4'b0100;
    tick(1);
    clr = '0;
    check("z2_cleared", 32'(cond), 32'h00);
`else
    check("z2_autoclear", 32'(cond), 32'h00);
`endif
    check("z2_scan_code_held", 32'(code), 32'h3);
    tick(1);
    check("z2_irq_drop", 32'(irq), 32'h0);

    // Zone 0 timeout, one cycle short of the limit.
    irr = 4'b0001;
    tick(7);
    spr = 4'b0001;
    tick(2);
    check("z0_short_c9", 32'(cond), 32'h00);
    tick(1);
    check("z0_short_c10", 32'(cond), 32'h01);
    tick(1);
    check("z0_short_c11", 32'(cond), 32'h01);
    check("z0_short_irq", 32'(irq), 32'h0);
    irr = '0; spr = '0;
    tick(3);
    check("z0_short_drop", 32'(cond), 32'h00);

    // Zone 0 timeout reaching the limit.
    irr = 4'b0001;
    tick(9);
    check("z0_full_c9", 32'(cond), 32'h00);
    tick(1);
    check("z0_full_c10", 32'(cond), 32'h03);
    tick(1);
    check("z0_full_irq", 32'(irq), 32'h1);
    irr = '0;
    tick(3);
`ifdef IRRIGATION_FAULT_LATCH_EN
    check("z0_drop3", 32'(cond), 32'h03);
`else
    check("z0_drop3", 32'(cond), 32'h00);
`endif
    clr = 4'b0001;
    tick(1);
    clr = '0;
    check("z0_cleared", 32'(cond), 32'h00);
    tick(1);
    check("z0_irq_drop", 32'(irq), 32'h0);

    // Zone 3: set wins over a simultaneous clear.
    spr = 4'b1000; drip = 4'b1000;
    tick(3);
    check("z3_fault_code", 32'(cond), 32'hC0);
    clr = 4'b1000;
    tick(1);
    clr = '0;
    check("z3_set_wins", 32'(cond), 32'hC0);
    check("z3_irq", 32'(irq), 32'h1);
    spr = '0; drip = '0;
    tick(3);
    clr = 4'b1000;
    tick(1);
    clr = '0;
    check("z3_cleared", 32'(cond), 32'h00);
    tick(1);
    check("z3_irq_drop", 32'(irq), 32'h0);

    // Reset mid-scan with zone 2 faulted.
    ready = 1'b1;
    spr = 4'b0100; drip = 4'b0100;
    tick(3);
    check("rst2_fault_code", 32'(cond), 32'h30);
    tick(1);
    check("rst2_irq", 32'(irq), 32'h1);
    check("rst2_pre_zone", 32'(zone), 32'h2);
    check("rst2_pre_code", 32'(code), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_cond", 32'(cond), 32'h00);
    check("rst2_irq_low", 32'(irq), 32'h0);
    check("rst2_valid", 32'(valid), 32'h0);
    check("rst2_zone", 32'(zone), 32'h0);
    check("rst2_code", 32'(code), 32'h0);
    spr = '0; drip = '0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("rst2_rel1_valid", 32'(valid), 32'h0);
    check("rst2_rel1_zone", 32'(zone), 32'h0);
    tick(1);
    check("rst2_rel2_valid", 32'(valid), 32'h1);
    check("rst2_rel2_zone", 32'(zone), 32'h0);
    tick(1);
    check("rst2_rel3_zone", 32'(zone), 32'h1);
    check("rst2_rel3_cond", 32'(cond), 32'h00);
    check("rst2_rel3_irq", 32'(irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
